fft_output_streamer: RTL and testbench

FFT_OUTPUT_STREAMER -- requirements
Module: fft_output_streamer

---
 rtl/fft_output_streamer.sv | 176 +++++++++++++++++
 tb/tb_fft_output_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_streamer.sv
// -----------------------------------------------------------------------------
// fft_output_streamer
//
// Purpose:
//   Takes one complete FFT output frame (all real and imaginary parts
//   presented in parallel) and replays it one complex sample per transfer on
//   a valid/ready stream. While a frame is being streamed the block refuses
//   new frames. After the last sample it spends one cycle idle before it can
//   capture the next frame.
//
// Parameters:
//   buffer_size  number of complex samples per frame (power of two, >= 2)
//   sample_size  bit width of each signed real/imag sample
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   frame_real    packed real parts, sample k at [k*sample_size +: sample_size]
//   frame_imag    packed imag parts, same packing as frame_real
//   frame_valid   frame_real/frame_imag hold a complete frame
//   frame_ready   block can capture a frame this cycle
//   sample_real   real part of the current streamed sample
//   sample_imag   imag part of the current streamed sample
//   sample_index  frequency-bin index of the current sample
//   sample_valid  sample_real/imag/index/last are valid
//   sample_ready  downstream accepts the current sample
//   sample_last   current sample is the final one of the frame
//
// Configuration macro:
//   FFT_STREAM_BITREV_EN  when defined, bins are emitted in bit-reversed order
//                         (sample_index = bit-reverse of the position count);
//                         otherwise bins are emitted in natural order.
// -----------------------------------------------------------------------------
module fft_output_streamer #(
    parameter int buffer_size = 32,
    parameter int sample_size = 32
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [buffer_size*sample_size-1:0] frame_real,
    input  logic [buffer_size*sample_size-1:0] frame_imag,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    output logic [sample_size-1:0]             sample_real,
    output logic [sample_size-1:0]             sample_imag,
    output logic [$clog2(buffer_size)-1:0]     sample_index,
    output logic                               sample_valid,
    input  logic                               sample_ready,
    output logic                               sample_last
);

    localparam int idx_w = $clog2(buffer_size);
    localparam logic [idx_w-1:0] last_pos = idx_w'(buffer_size - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t state_next;

    logic [idx_w-1:0]       position;
    logic [idx_w-1:0]       read_index;
    logic                   at_last;
    logic                   capture;
    logic                   advance;

    logic [sample_size-1:0] buf_real [buffer_size];
    logic [sample_size-1:0] buf_imag [buffer_size];

`ifdef FFT_STREAM_BITREV_EN
    // Mirror the bit order of the position count so that bins come out in
    // bit-reversed order.
    function automatic logic [idx_w-1:0] bit_reverse(input logic [idx_w-1:0] value);
        logic [idx_w-1:0] result;
        result = '0;
        for (int b = 0; b < idx_w; b++) begin
            result[b] = value[idx_w-1-b];
        end
        return result;
    endfunction
`endif

    // State register. Reset always lands in IDLE, so a frame that was being
    // streamed is dropped and is never resumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A frame is only accepted in IDLE, so
    // frame_valid during STREAM cannot overwrite the buffer. The transfer that
    // carries the final sample sends the FSM back to IDLE.
    always_comb begin
        state_next   = state;
        frame_ready  = 1'b0;
        sample_valid = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                sample_valid = 1'b1;
                if (sample_ready) begin
                    advance = 1'b1;
                    if (at_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Position counter. It is cleared on capture and moves only on an
    // accepted transfer. At the last position it holds instead of wrapping.
    // The next capture clears it again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position <= '0;
        end else if (capture) begin
            position <= '0;
        end else if (advance && !at_last) begin
            position <= position + 1'b1;
        end
    end

    // Frame buffer. It only changes on capture. Its contents need no reset
    // because the outputs are masked whenever the FSM is not streaming.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < buffer_size; k++) begin
                buf_real[k] <= frame_real[k*sample_size +: sample_size];
                buf_imag[k] <= frame_imag[k*sample_size +: sample_size];
            end
        end
    end

    assign at_last = (position == last_pos);

`ifdef FFT_STREAM_BITREV_EN
    assign read_index = bit_reverse(position);
`else
    assign read_index = position;
`endif

    // Sample outputs. They are built only from the state register, the
    // position counter and the buffer, so there is no path from frame_* to
    // sample_*. Outside STREAM every field is forced to zero. This gives the
    // required all-zero outputs during reset without resetting the buffer.
    always_comb begin
        sample_real  = '0;
        sample_imag  = '0;
        sample_index = '0;
        sample_last  = 1'b0;
        if (state == STREAM) begin
            sample_real  = buf_real[read_index];
            sample_imag  = buf_imag[read_index];
            sample_index = read_index;
            sample_last  = at_last;
        end
    end

endmodule

// File: tb/tb_fft_output_streamer.sv
// -----------------------------------------------------------------------------
// tb_fft_output_streamer
//
// Self-checking bench for fft_output_streamer. A queue-based reference model
// keeps the samples a captured frame must produce. It is compared against
// the DUT on every falling edge. Directed tests add literal expectations that
// pin the model down.
// -----------------------------------------------------------------------------
module tb_fft_output_streamer;

`ifdef FFT_STREAM_BITREV_EN
    localparam int N = 8;
`else
    localparam int N = 32;
`endif
    localparam int SS = 32;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              reset_n;
    logic [N*SS-1:0]   frame_real;
    logic [N*SS-1:0]   frame_imag;
    logic              frame_valid;
    logic              frame_ready;
    logic [SS-1:0]     sample_real;
    logic [SS-1:0]     sample_imag;
    logic [IW-1:0]     sample_index;
    logic              sample_valid;
    logic              sample_ready;
    logic              sample_last;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic [SS-1:0] re;
        logic [SS-1:0] im;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t q[$];
    bit   m_stream = 1'b0;

    // Transfers the DUT actually performed, recorded for the directed checks
    logic [SS-1:0] seen_real[$];
    logic [SS-1:0] seen_imag[$];
    logic [IW-1:0] seen_idx[$];
    logic          seen_last[$];

    fft_output_streamer #(
        .buffer_size(N),
        .sample_size(SS)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_real(frame_real),
        .frame_imag(frame_imag),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .sample_real(sample_real),
        .sample_imag(sample_imag),
        .sample_index(sample_index),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_last(sample_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Position p of the stream carries bin p in natural order, or the
    // bit-reversed bin number when the option is enabled.
    function automatic int bin_of(input int p);
`ifdef FFT_STREAM_BITREV_EN
        int r = 0;
        for (int b = 0; b < IW; b++) begin
            if (((p >> b) & 1) != 0) r = r | (1 << (IW - 1 - b));
        end
        return r;
`else
        return p;
`endif
    endfunction

    // Reference model and compare process. Checks run on the falling edge.
    // Then the model applies the handshake that the next rising edge sees.
    always @(negedge clk) begin
        if (!reset_n) begin
            checkOutput("rst frame_ready", 64'(frame_ready), 64'd1);
            checkOutput("rst sample_valid", 64'(sample_valid), 64'd0);
            checkOutput("rst sample_last", 64'(sample_last), 64'd0);
            checkOutput("rst sample_index", 64'(sample_index), 64'd0);
            checkOutput("rst sample_real", 64'(sample_real), 64'd0);
            checkOutput("rst sample_imag", 64'(sample_imag), 64'd0);
            q.delete();
            m_stream = 1'b0;
        end else begin
            checkOutput("frame_ready", 64'(frame_ready), 64'(!m_stream));
            checkOutput("sample_valid", 64'(sample_valid), 64'(m_stream));
            if (m_stream && q.size() > 0) begin
                checkOutput("sample_index", 64'(sample_index), 64'(q[0].idx));
                checkOutput("sample_real", 64'(sample_real), 64'(q[0].re));
                checkOutput("sample_imag", 64'(sample_imag), 64'(q[0].im));
                checkOutput("sample_last", 64'(sample_last), 64'(q[0].last));
            end else begin
                checkOutput("idle sample_last", 64'(sample_last), 64'd0);
            end
            if (sample_valid && sample_ready) begin
                seen_real.push_back(sample_real);
                seen_imag.push_back(sample_imag);
                seen_idx.push_back(sample_index);
                seen_last.push_back(sample_last);
            end
            if (m_stream) begin
                if (sample_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_stream = 1'b0;
                end
            end else if (frame_valid) begin
                for (int p = 0; p < N; p++) begin
                    exp_t e;
                    int   b;
                    b      = bin_of(p);
                    e.re   = frame_real[b*SS +: SS];
                    e.im   = frame_imag[b*SS +: SS];
                    e.idx  = IW'(b);
                    e.last = (p == N - 1);
                    q.push_back(e);
                end
                m_stream = 1'b1;
            end
        end
    end

    task automatic clearSeen();
        seen_real.delete();
        seen_imag.delete();
        seen_idx.delete();
        seen_last.delete();
    endtask

    task automatic loadFrame(input int re_base, input int re_step, input int im_base, input int im_step);
        for (int k = 0; k < N; k++) begin
            frame_real[k*SS +: SS] = SS'(re_base + re_step * k);
            frame_imag[k*SS +: SS] = SS'(im_base + im_step * k);
        end
    endtask

    // Present the frame for one clock.
    task automatic applyStimulus();
        @(posedge clk);
        #1 frame_valid = 1'b1;
        @(posedge clk);
        #1 frame_valid = 1'b0;
    endtask

    // Wait for the requested number of transfers, or report a timeout
    task automatic waitTransfers(input int target, input int budget);
        int c = 0;
        while (seen_idx.size() < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        checkOutput("transfer wait timeout", 64'(seen_idx.size() >= target), 64'd1);
    endtask

    initial begin
        int lasts;
        int sum;
        int pat[4];
        int injectAt;
        int hits;
        logic [N-1:0] mask;
        bit injected;
        bit done;
        logic [SS-1:0] orig[N];

        pat = '{1, 0, 0, 1};
        reset_n      = 1'b0;
        frame_valid  = 1'b0;
        sample_ready = 1'b0;
        frame_real   = '0;
        frame_imag   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset frame_ready", 64'(frame_ready), 64'd1);
        checkOutput("reset sample_valid", 64'(sample_valid), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Natural order, unconditional ready
        $display("[TB] natural order frame");
        clearSeen();
        loadFrame(4, 1, 1, 1);
        sample_ready = 1'b1;
        applyStimulus();
        waitTransfers(N, 4 * N);
        @(negedge clk);
        checkOutput("nat frame_ready after", 64'(frame_ready), 64'd1);
        checkOutput("nat count", 64'(seen_idx.size()), 64'(N));
        if (seen_idx.size() == N) begin
            checkOutput("nat first real", 64'(seen_real[0]), 64'd4);
            checkOutput("nat first imag", 64'(seen_imag[0]), 64'd1);
            checkOutput("nat last index", 64'(seen_idx[N-1]), 64'(N - 1));
            checkOutput("nat last real", 64'(seen_real[N-1]), 64'(N + 3));
            checkOutput("nat last flag", 64'(seen_last[N-1]), 64'd1);
            lasts = 0;
            for (int i = 0; i < N; i++) lasts += int'(seen_last[i]);
            checkOutput("nat last count", 64'(lasts), 64'd1);
        end

        // Backpressure pattern plus an ignored frame mid-stream
        $display("[TB] backpressure and ignored frame");
        clearSeen();
        loadFrame(-7, 3, 100, -5);
        for (int k = 0; k < N; k++) orig[k] = frame_real[k*SS +: SS];
        applyStimulus();
        injectAt = (N > 10) ? 10 : N / 2;
        injected = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 8 * N && !done; c++) begin
            @(posedge clk);
            #1;
            if (seen_idx.size() >= N) begin
                done = 1'b1;
            end else begin
                sample_ready = (pat[c % 4] != 0);
                frame_valid  = 1'b0;
                if (!injected && seen_idx.size() == injectAt) begin
                    for (int k = 0; k < N; k++) frame_real[k*SS +: SS] = 32'h7FFFFFFF;
                    frame_valid = 1'b1;
                    injected    = 1'b1;
                end
            end
        end
        frame_valid  = 1'b0;
        sample_ready = 1'b1;
        checkOutput("bp completed", 64'(done), 64'd1);
        checkOutput("bp count", 64'(seen_idx.size()), 64'(N));
        mask = '0;
        sum  = 0;
        hits = 0;
        for (int i = 0; i < seen_idx.size(); i++) begin
            mask[seen_idx[i]] = 1'b1;
            sum += int'(seen_idx[i]);
            if (seen_real[i] == 32'h7FFFFFFF) hits++;
            if (seen_real[i] != orig[seen_idx[i]]) hits++;
        end
        checkOutput("bp every index once", 64'(mask), 64'({N{1'b1}}));
        checkOutput("bp index sum", 64'(sum), 64'(N * (N - 1) / 2));
        checkOutput("bp data from original", 64'(hits), 64'd0);
        repeat (2) @(posedge clk);

        // Signed pass-through
        $display("[TB] signed pass-through");
        clearSeen();
        loadFrame(0, 1, 0, 1);
        frame_real[0 +: SS] = 32'hFFFFFFFF;
        frame_imag[0 +: SS] = 32'hFFFF8000;
        applyStimulus();
        waitTransfers(N, 4 * N);
        if (seen_idx.size() > 0) begin
            checkOutput("signed real", 64'(seen_real[0]), 64'hFFFFFFFF);
            checkOutput("signed imag", 64'(seen_imag[0]), 64'hFFFF8000);
        end
        repeat (2) @(posedge clk);

`ifdef FFT_STREAM_BITREV_EN
        // Bit-reversed order
        $display("[TB] bit-reversed order");
        begin
            int order[8];
            order = '{0, 4, 2, 6, 1, 5, 3, 7};
            clearSeen();
            loadFrame(0, 1, 0, 0);
            applyStimulus();
            waitTransfers(N, 4 * N);
            for (int i = 0; i < 8 && i < seen_idx.size(); i++) begin
                checkOutput("bitrev index", 64'(seen_idx[i]), 64'(order[i]));
                checkOutput("bitrev real", 64'(seen_real[i]), 64'(order[i]));
                checkOutput("bitrev last", 64'(seen_last[i]), 64'(i == 7));
            end
            repeat (2) @(posedge clk);
        end
`endif

        // Reset in the middle of a stream
        $display("[TB] reset mid-stream");
        clearSeen();
        loadFrame(20, 2, 30, 3);
        applyStimulus();
        waitTransfers(5, 4 * N);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst sample_valid", 64'(sample_valid), 64'd0);
        checkOutput("midrst frame_ready", 64'(frame_ready), 64'd1);
        checkOutput("midrst sample_last", 64'(sample_last), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        checkOutput("midrst no resume", 64'(seen_idx.size()), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
